// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data memory port between the core load/store
// path and a host requester (program loader / debug port).
// Optional feature macro: DMEM_ARB_FAIR_EN enables the host burst lock and the
// fairness preempt, both bounded by MaxRun. Without it, the core has strict
// priority and the host only uses cycles the core leaves idle.
module dmem_arbiter #(
  parameter int AddressWidth = 10,
  parameter int MaxRun       = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // core load/store path
  input  logic                    core_req_i,
  input  logic                    core_wr_en_i,
  input  logic [AddressWidth-1:0] core_addr_i,
  input  logic [31:0]             core_wr_data_i,
  input  logic [2:0]              core_funct3_i,
  output logic                    core_stall_o,
  output logic [31:0]             core_r_data_o,
  // host requester
  input  logic                    host_req_i,
  input  logic                    host_wr_en_i,
  input  logic [AddressWidth-1:0] host_addr_i,
  input  logic [31:0]             host_wr_data_i,
  input  logic [2:0]              host_funct3_i,
  output logic                    host_gnt_o,
  output logic                    host_rvalid_o,
  output logic [31:0]             host_r_data_o,
  // data memory port
  output logic                    mem_r_en_o,
  output logic                    mem_wr_en_o,
  output logic [AddressWidth-1:0] mem_addr_o,
  output logic [31:0]             mem_wr_data_o,
  output logic [2:0]              mem_funct3_o,
  input  logic [31:0]             mem_r_data_i
);

  logic core_gnt;
  logic host_gnt;

`ifdef DMEM_ARB_FAIR_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORE = 2'd1,
    HOST = 2'd2
  } owner_e;

  localparam logic [7:0] RunMax = 8'(MaxRun);

  owner_e     state_q;
  logic [7:0] run_cnt_q;
  logic       lock_ok;

  // Grant decision: host burst lock, then fairness preempt, then core priority.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the if/else chain can leave it unassigned and infer a latch.
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    lock_ok  = (run_cnt_q < RunMax) || !core_req_i;
    if (host_req_i && state_q == HOST && lock_ok) begin
      host_gnt = 1'b1;
    end else if (host_req_i && state_q == CORE && run_cnt_q == RunMax) begin
      host_gnt = 1'b1;
    end else if (core_req_i) begin
      core_gnt = 1'b1;
    end else if (host_req_i) begin
      host_gnt = 1'b1;
    end
  end

  // Owner FSM and run-length counter: remember who held the port last cycle
  // and for how many consecutive cycles.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      run_cnt_q <= 8'd0;
    end else if (core_gnt) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q   <= CORE;
      run_cnt_q <= (state_q != CORE) ? 8'd1
                 : (run_cnt_q < RunMax) ? run_cnt_q + 8'd1 : run_cnt_q;
    end else if (host_gnt) begin
      state_q   <= HOST;
      run_cnt_q <= (state_q != HOST) ? 8'd1
                 : (run_cnt_q < RunMax) ? run_cnt_q + 8'd1 : run_cnt_q;
    end else begin
      state_q   <= IDLE;
      run_cnt_q <= 8'd0;
    end
  end
`else
  // Strict core priority: the host only gets cycles the core leaves idle, so
  // no ownership history is needed.
  always_comb begin
    core_gnt = core_req_i;
    host_gnt = host_req_i && !core_req_i;
  end
`endif

  // Memory port mux: the granted side drives the port; with no grant the core
  // fields pass through with both enables held low.
  always_comb begin
    if (host_gnt) begin
      mem_addr_o    = host_addr_i;
      mem_wr_data_o = host_wr_data_i;
      mem_funct3_o  = host_funct3_i;
      mem_wr_en_o   = host_wr_en_i;
      mem_r_en_o    = !host_wr_en_i;
    end else begin
      mem_addr_o    = core_addr_i;
      mem_wr_data_o = core_wr_data_i;
      mem_funct3_o  = core_funct3_i;
      mem_wr_en_o   = core_gnt && core_wr_en_i;
      mem_r_en_o    = core_gnt && !core_wr_en_i;
    end
  end

  // Requester-facing status.
  always_comb begin
    core_stall_o  = core_req_i && !core_gnt;
    core_r_data_o = mem_r_data_i;
    host_gnt_o    = host_gnt;
  end

  // Host read return: capture the memory read on a granted host read and
  // present it for exactly one cycle afterwards.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      host_rvalid_o <= 1'b0;
      host_r_data_o <= 32'd0;
    end else begin
      host_rvalid_o <= host_gnt && !host_wr_en_i;
      if (host_gnt && !host_wr_en_i) begin
        host_r_data_o <= mem_r_data_i;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a word-wide behavioural data memory.
// Expectations follow DMEM_ARB_FAIR_EN when it is defined for the build.
module tb_dmem_arbiter;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          core_req, core_wr_en;
  logic [AW-1:0] core_addr;
  logic [31:0]   core_wr_data;
  logic [2:0]    core_funct3;
  logic          core_stall;
  logic [31:0]   core_r_data;
  logic          host_req, host_wr_en;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wr_data;
  logic [2:0]    host_funct3;
  logic          host_gnt, host_rvalid;
  logic [31:0]   host_r_data;
  logic          mem_r_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wr_data;
  logic [2:0]    mem_funct3;
  logic [31:0]   mem_r_data;

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Combinational-read, clocked-write data memory (word accesses only).
  assign mem_r_data = mem[mem_addr[AW-1:2]];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr[AW-1:2]] <= mem_wr_data;

  dmem_arbiter #(.AddressWidth(AW), .MaxRun(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .core_req_i(core_req), .core_wr_en_i(core_wr_en), .core_addr_i(core_addr),
    .core_wr_data_i(core_wr_data), .core_funct3_i(core_funct3),
    .core_stall_o(core_stall), .core_r_data_o(core_r_data),
    .host_req_i(host_req), .host_wr_en_i(host_wr_en), .host_addr_i(host_addr),
    .host_wr_data_i(host_wr_data), .host_funct3_i(host_funct3),
    .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid), .host_r_data_o(host_r_data),
    .mem_r_en_o(mem_r_en), .mem_wr_en_o(mem_wr_en), .mem_addr_o(mem_addr),
    .mem_wr_data_o(mem_wr_data), .mem_funct3_o(mem_funct3), .mem_r_data_i(mem_r_data)
  );

  task automatic set_core(input logic req, input logic wr, input logic [AW-1:0] addr,
                          input logic [31:0] data);
    core_req = req; core_wr_en = wr; core_addr = addr; core_wr_data = data;
    core_funct3 = 3'b010;
  endtask

  task automatic set_host(input logic req, input logic wr, input logic [AW-1:0] addr,
                          input logic [31:0] data);
    host_req = req; host_wr_en = wr; host_addr = addr; host_wr_data = data;
    host_funct3 = 3'b010;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      core_req = 1'($urandom); core_wr_en = 1'($urandom); core_addr = AW'($urandom);
      core_wr_data = $urandom; core_funct3 = 3'($urandom);
      host_req = 1'($urandom); host_wr_en = 1'($urandom); host_addr = AW'($urandom);
      host_wr_data = $urandom; host_funct3 = 3'($urandom);
      step();
      checks++;
      if (host_rvalid !== 1'b0) begin
        errors++; $display("FAIL reset_rvalid[%0d]: got %b expected 0", i, host_rvalid);
      end
    end
    set_core(1'b1, 1'b0, 10'h10, 32'd0);
    set_host(1'b1, 1'b0, 10'h20, 32'd0);
    #1;
    checks++;
    if (host_gnt !== 1'b0 || core_stall !== 1'b0) begin
      errors++; $display("FAIL reset_idle_prio: host_gnt=%b core_stall=%b expected 0/0",
                         host_gnt, core_stall);
    end
    set_core(1'b0, 1'b0, 10'h0, 32'd0);
    set_host(1'b0, 1'b0, 10'h0, 32'd0);
    #1 rst_i = 1'b1;
    step();
    checks++;
    if (host_rvalid !== 1'b0 || host_r_data !== 32'd0) begin
      errors++; $display("FAIL reset_release: rvalid=%b rdata=%h expected 0/00000000",
                         host_rvalid, host_r_data);
    end
    checks++;
    if (host_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_no_req_gnt: host_gnt=%b expected 0", host_gnt);
    end
  endtask

  task automatic test_core_only();
    set_core(1'b1, 1'b1, 10'h10, 32'hDEADBEEF);
    #1;
    checks++;
    if (core_stall !== 1'b0 || mem_wr_en !== 1'b1 || mem_addr !== 10'h10) begin
      errors++; $display("FAIL core_store: stall=%b wr_en=%b addr=%h expected 0/1/010",
                         core_stall, mem_wr_en, mem_addr);
    end
    step();
    set_core(1'b1, 1'b0, 10'h10, 32'd0);
    #1;
    checks++;
    if (core_stall !== 1'b0 || mem_r_en !== 1'b1 || mem_wr_en !== 1'b0) begin
      errors++; $display("FAIL core_load_ctl: stall=%b r_en=%b wr_en=%b expected 0/1/0",
                         core_stall, mem_r_en, mem_wr_en);
    end
    checks++;
    if (core_r_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL core_load_data: got %h expected deadbeef", core_r_data);
    end
    step();
    set_core(1'b0, 1'b0, 10'h0, 32'd0);
    #1;
    checks++;
    if (mem_r_en !== 1'b0 || mem_wr_en !== 1'b0 || core_stall !== 1'b0) begin
      errors++; $display("FAIL no_grant_enables: r_en=%b wr_en=%b stall=%b expected 0/0/0",
                         mem_r_en, mem_wr_en, core_stall);
    end
    step();
  endtask

  task automatic test_simultaneous();
    set_core(1'b1, 1'b0, 10'h10, 32'd0);
    set_host(1'b1, 1'b0, 10'h10, 32'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (core_stall !== 1'b0 || host_gnt !== 1'b0) begin
        errors++; $display("FAIL simul_core_wins[%0d]: stall=%b host_gnt=%b expected 0/0",
                           i, core_stall, host_gnt);
      end
      step();
    end
    set_core(1'b0, 1'b0, 10'h0, 32'd0);
    #1;
    checks++;
    if (host_gnt !== 1'b1 || core_stall !== 1'b0) begin
      errors++; $display("FAIL simul_host_after: host_gnt=%b stall=%b expected 1/0",
                         host_gnt, core_stall);
    end
    step();
    set_host(1'b0, 1'b0, 10'h0, 32'd0);
    checks++;
    if (host_rvalid !== 1'b1 || host_r_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL simul_host_rdata: rvalid=%b rdata=%h expected 1/deadbeef",
                         host_rvalid, host_r_data);
    end
    step();
  endtask

  task automatic test_host_read();
    set_host(1'b1, 1'b1, 10'h20, 32'h12345678);
    #1;
    checks++;
    if (host_gnt !== 1'b1 || mem_wr_en !== 1'b1 || mem_addr !== 10'h20 ||
        mem_wr_data !== 32'h12345678) begin
      errors++; $display("FAIL host_write: gnt=%b wr_en=%b addr=%h data=%h expected 1/1/020/12345678",
                         host_gnt, mem_wr_en, mem_addr, mem_wr_data);
    end
    step();
    set_host(1'b1, 1'b0, 10'h20, 32'd0);
    checks++;
    if (host_rvalid !== 1'b0) begin
      errors++; $display("FAIL host_write_no_rvalid: got %b expected 0", host_rvalid);
    end
    #1;
    checks++;
    if (host_gnt !== 1'b1 || mem_r_en !== 1'b1) begin
      errors++; $display("FAIL host_read_gnt: gnt=%b r_en=%b expected 1/1", host_gnt, mem_r_en);
    end
    step();
    // Back-to-back second read of the address the core wrote earlier.
    set_host(1'b1, 1'b0, 10'h10, 32'd0);
    checks++;
    if (host_rvalid !== 1'b1 || host_r_data !== 32'h12345678) begin
      errors++; $display("FAIL host_read_data: rvalid=%b rdata=%h expected 1/12345678",
                         host_rvalid, host_r_data);
    end
    step();
    set_host(1'b0, 1'b0, 10'h0, 32'd0);
    checks++;
    if (host_rvalid !== 1'b1 || host_r_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL host_b2b_data: rvalid=%b rdata=%h expected 1/deadbeef",
                         host_rvalid, host_r_data);
    end
    step();
    checks++;
    if (host_rvalid !== 1'b0) begin
      errors++; $display("FAIL host_rvalid_one_cycle: got %b expected 0", host_rvalid);
    end
    step();
  endtask

  task automatic test_continuous();
    logic exp_host;
    set_core(1'b1, 1'b0, 10'h10, 32'd0);
    set_host(1'b1, 1'b0, 10'h20, 32'd0);
    for (int c = 0; c < 34; c++) begin
      #1;
`ifdef DMEM_ARB_FAIR_EN
      exp_host = ((c / 8) % 2) == 1;
`else
      exp_host = 1'b0;
`endif
      checks++;
      if (host_gnt !== exp_host || core_stall !== exp_host) begin
        errors++; $display("FAIL continuous[%0d]: host_gnt=%b stall=%b expected %b/%b",
                           c, host_gnt, core_stall, exp_host, exp_host);
      end
      step();
    end
    set_core(1'b0, 1'b0, 10'h0, 32'd0);
    set_host(1'b0, 1'b0, 10'h0, 32'd0);
    step();
  endtask

  task automatic test_reset_mid_burst();
    set_host(1'b1, 1'b0, 10'h20, 32'd0);
    step();
    step();
    checks++;
    if (host_rvalid !== 1'b1) begin
      errors++; $display("FAIL burst_rvalid: got %b expected 1", host_rvalid);
    end
    set_core(1'b1, 1'b0, 10'h10, 32'd0);
    rst_i = 1'b0;
    #1;
    checks++;
    if (host_rvalid !== 1'b0 || host_r_data !== 32'd0) begin
      errors++; $display("FAIL burst_reset_drop: rvalid=%b rdata=%h expected 0/00000000",
                         host_rvalid, host_r_data);
    end
    checks++;
    if (host_gnt !== 1'b0 || core_stall !== 1'b0) begin
      errors++; $display("FAIL burst_reset_idle: host_gnt=%b stall=%b expected 0/0",
                         host_gnt, core_stall);
    end
    step();
    set_core(1'b0, 1'b0, 10'h0, 32'd0);
    set_host(1'b0, 1'b0, 10'h0, 32'd0);
    rst_i = 1'b1;
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    test_reset();
    test_core_only();
    test_simultaneous();
    test_host_read();
    test_continuous();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data memory port between the core's load/store path and a host requester (program loader / debug port). It sits between the datapath's load/store signals and `data_mem`. The core is stalled whenever it loses arbitration. An optional fairness scheme bounds how long either side can hold the port.

## Interface
Parameters:
- `AddressWidth`, default 10: byte address width of the data memory.
- `MaxRun`, default 8: maximum consecutive grant cycles to one owner while the other side is waiting. Used only with fairness enabled; legal range 1..255.

Ports:
- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `core_req_i`  in  1  core load or store this cycle (mem read enable | mem write enable).
- `core_wr_en_i`  in  1  core store.
- `core_addr_i`  in  AddressWidth  core byte address.
- `core_wr_data_i`  in  32  core store data.
- `core_funct3_i`  in  3  core access size/sign.
- `core_stall_o`  out  1  core request not granted; core must hold PC and all state.
- `core_r_data_o`  out  32  load data, combinational from memory.
- `host_req_i`  in  1  host access request; held until granted.
- `host_wr_en_i`  in  1  host write.
- `host_addr_i`  in  AddressWidth  host byte address.
- `host_wr_data_i`  in  32  host write data.
- `host_funct3_i`  in  3  host access size/sign.
- `host_gnt_o`  out  1  host access performed this cycle.
- `host_rvalid_o`  out  1  registered host read data valid.
- `host_r_data_o`  out  32  registered host read data.
- `mem_r_en_o`, `mem_wr_en_o`  out  1 each  to `data_mem`.
- `mem_addr_o`  out  AddressWidth  to `data_mem`.
- `mem_wr_data_o`  out  32  to `data_mem`.
- `mem_funct3_o`  out  3  to `data_mem`.
- `mem_r_data_i`  in  32  from `data_mem`, combinational read.

## Operation
- Owner FSM with states IDLE, CORE and HOST. The state records who was granted last cycle. The grant for the current cycle is decided combinationally from state, requests and `run_cnt`.
- Grant rules, in priority order:
  - If `host_req_i`, state is HOST and lock is allowed, grant the host (burst lock).
  - Else if `host_req_i`, state is CORE and `run_cnt == MaxRun`, grant the host (fairness preempt).
  - Else if `core_req_i`, grant the core.
  - Else if `host_req_i`, grant the host.
  - Else no grant; outputs are muxed to the core with enables forced to 0.
- Lock is allowed while `run_cnt < MaxRun`, or while `core_req_i` is 0.
- Next state is CORE or HOST per the grant, or IDLE when nothing is granted.
- `run_cnt` sets to 1 on a grant to a new owner, or when leaving IDLE. It increments on each consecutive grant to the same owner and saturates at `MaxRun`. It clears to 0 on no grant.
- Mux: the granted requester's addr, wr_data and funct3 drive the `mem_*` outputs. `mem_wr_en_o` equals the granted side's wr_en. `mem_r_en_o` equals the granted side's `req & ~wr_en`.
- `core_stall_o = core_req_i & ~core_gnt`. `host_gnt_o = host_gnt`.
- `core_r_data_o = mem_r_data_i` at all times. It is meaningful only when the core is granted.
- Host read: on a cycle with host granted and `host_wr_en_i = 0`, capture `mem_r_data_i` into `host_r_data_o` and set `host_rvalid_o` the next cycle for exactly 1 cycle. Host writes never raise `host_rvalid_o`.
- Simultaneous requests from IDLE: the core wins.

## Timing
- Reset values: state IDLE, `run_cnt` 0, `host_rvalid_o` 0, `host_r_data_o` 0.
- Combinational outputs during reset follow the IDLE rules (core has priority).
- Grant has zero latency. Writes commit at the same rising edge through `data_mem`.
- Core read latency is 0 cycles. Host read latency is 1 cycle (`host_rvalid_o` asserts the cycle after `host_gnt_o`).
- A host stream can be back-to-back: one access per cycle while it holds the lock.
- Reset asserted mid-burst: state returns to IDLE immediately and a pending `host_rvalid_o` is dropped.

## Configuration
- `DMEM_ARB_FAIR_EN` defined: burst lock and fairness preempt as above, bounded by `MaxRun`.
- Undefined: strict core priority, with no lock and no preempt. The host is granted only in cycles with `core_req_i = 0`. `run_cnt` logic is removed.

## Test plan
- Reset: hold `rst_i = 0` with random inputs, then release. Expect `host_rvalid_o = 0`, `host_r_data_o = 0`, and an unrequested host not granted.
- Core only: store 0xDEADBEEF to address 0x10, then load from 0x10. Expect `core_stall_o = 0` both cycles and `core_r_data_o = 0xDEADBEEF`.
- Simultaneous from IDLE: core and host both request. Expect core granted, `core_stall_o = 0`, `host_gnt_o = 0`. Host granted the first cycle `core_req_i` drops.
- Host read: write 0x12345678 to address 0x20 via the host, then read it. Expect `host_rvalid_o = 1` for exactly one cycle, one cycle after grant, with `host_r_data_o = 0x12345678`.
- Fairness (`DMEM_ARB_FAIR_EN`, `MaxRun = 8`): core and host request continuously. Expect the grant to alternate in 8-cycle runs, with `core_stall_o` high exactly during the host runs.
- Strict mode (macro undefined): the same continuous-request stimulus. Expect the host never granted and `core_stall_o = 0` throughout.
